// File: rtl/mips_control_fsm.sv
// Multi-cycle FETCH/EXEC1/EXEC2/HALT sequencer for the MIPS core: Avalon stalls, counted mult/div stall.
// Optional build macro MIPS_CTRL_WATCHDOG_EN adds a waitrequest watchdog that raises a sticky fault.
module mips_control_fsm #(
    parameter int MULDIV_CYCLES  = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       waitrequest,
    input  logic       halt_req,
    input  logic       is_load,
    input  logic       is_store,
    input  logic       is_muldiv,
    output logic [1:0] state,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_load,
    output logic       pc_en,
    output logic       extra,
    output logic       muldiv_busy,
    output logic       active,
    output logic       fault
);

    localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC1 = 2'b01,
        S_EXEC2 = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    state_t           state_fsm;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic rd_raw;
    logic wr_raw;
    logic irl_raw;
    logic pce_raw;
    logic ext_raw;
    logic busy_raw;

    logic cls_load;
    logic cls_store;
    logic cls_muldiv;
    logic wd_expire;

    // Priority is load > store > muldiv > other when the decoder flags overlap.
    assign cls_load   = is_load;
    assign cls_store  = !is_load && is_store;
    assign cls_muldiv = !is_load && !is_store && is_muldiv;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_fsm = state_q;
        cnt_d     = cnt_q;
        rd_raw    = 1'b0;
        wr_raw    = 1'b0;
        irl_raw   = 1'b0;
        pce_raw   = 1'b0;
        ext_raw   = 1'b0;
        busy_raw  = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (halt_req) begin
                    state_fsm = S_HALT;
                end else begin
                    rd_raw = 1'b1;
                    if (!waitrequest) begin
                        irl_raw   = 1'b1;
                        state_fsm = S_EXEC1;
                    end
                end
            end

            S_EXEC1: begin
                ext_raw = is_load || is_muldiv;
                if (cls_load) begin
                    rd_raw = 1'b1;
                    if (!waitrequest) begin
                        state_fsm = S_EXEC2;
                    end
                end else if (cls_store) begin
                    wr_raw = 1'b1;
                    if (!waitrequest) begin
                        pce_raw   = 1'b1;
                        state_fsm = S_FETCH;
                    end
                end else if (cls_muldiv) begin
                    cnt_d     = CNT_LOAD;
                    state_fsm = S_EXEC2;
                end else begin
                    pce_raw   = 1'b1;
                    state_fsm = S_FETCH;
                end
            end

            // Loads spend one writeback cycle here; mult/div sits until the counter drains to zero.
            S_EXEC2: begin
                ext_raw = is_load || is_muldiv;
                if (cls_muldiv) begin
                    if (cnt_q == '0) begin
                        pce_raw   = 1'b1;
                        state_fsm = S_FETCH;
                    end else begin
                        busy_raw = 1'b1;
                        cnt_d    = cnt_q - CNT_W'(1);
                    end
                end else begin
                    pce_raw   = 1'b1;
                    state_fsm = S_FETCH;
                end
            end

            S_HALT: begin
                state_fsm = S_HALT;
            end

            default: begin
                state_fsm = S_HALT;
            end
        endcase
    end

`ifdef MIPS_CTRL_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_q;
    logic        fault_q;

    // Counts back-to-back stalled strobe cycles; any cycle without waitrequest restarts the count.
    assign wd_expire = (rd_raw || wr_raw) && waitrequest && (wd_q == WD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            if (!waitrequest) begin
                wd_q <= '0;
            end else if (rd_raw || wr_raw) begin
                wd_q <= wd_q + 16'd1;
            end
            if (wd_expire) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign fault = fault_q;
`else
    assign wd_expire = 1'b0;
    assign fault     = 1'b0;
`endif

    assign state_d = wd_expire ? S_HALT : state_fsm;

    // Strobes are held low while reset is asserted so the datapath sees no stray handshake.
    assign state       = state_q;
    assign mem_read    = reset_n && rd_raw;
    assign mem_write   = reset_n && wr_raw;
    assign ir_load     = reset_n && irl_raw;
    assign pc_en       = reset_n && pce_raw;
    assign extra       = reset_n && ext_raw;
    assign muldiv_busy = reset_n && busy_raw;
    assign active      = (state_q != S_HALT);

    ap_no_irl_pce_overlap: assert property (@(posedge clk) disable iff (!reset_n) !(ir_load && pc_en));

endmodule

// File: tb/tb_mips_control_fsm.sv
// Self-checking bench for mips_control_fsm: table-driven instruction sequences plus multi-cycle corner cases.
module tb_mips_control_fsm;

    logic clk;
    logic reset_n;
    logic waitrequest;
    logic halt_req;
    logic is_load;
    logic is_store;
    logic is_muldiv;

    logic [1:0] a_state;
    logic a_mem_read, a_mem_write, a_ir_load, a_pc_en, a_extra, a_busy, a_active, a_fault;
    logic [1:0] b_state;
    logic b_mem_read, b_mem_write, b_ir_load, b_pc_en, b_extra, b_busy, b_active, b_fault;

    int tests_run = 0;
    int tests_failed = 0;

    mips_control_fsm #(.MULDIV_CYCLES(4), .TIMEOUT_CYCLES(8)) dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .waitrequest (waitrequest),
        .halt_req    (halt_req),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_muldiv   (is_muldiv),
        .state       (a_state),
        .mem_read    (a_mem_read),
        .mem_write   (a_mem_write),
        .ir_load     (a_ir_load),
        .pc_en       (a_pc_en),
        .extra       (a_extra),
        .muldiv_busy (a_busy),
        .active      (a_active),
        .fault       (a_fault)
    );

    mips_control_fsm #(.MULDIV_CYCLES(1), .TIMEOUT_CYCLES(8)) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .waitrequest (waitrequest),
        .halt_req    (halt_req),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_muldiv   (is_muldiv),
        .state       (b_state),
        .mem_read    (b_mem_read),
        .mem_write   (b_mem_write),
        .ir_load     (b_ir_load),
        .pc_en       (b_pc_en),
        .extra       (b_extra),
        .muldiv_busy (b_busy),
        .active      (b_active),
        .fault       (b_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs {reset_n, waitrequest, halt_req, is_load, is_store, is_muldiv};
    // expected {state[1:0], mem_read, mem_write, ir_load, pc_en, extra, muldiv_busy, active, fault}.
    typedef struct {
        logic [5:0] stim;
        logic [9:0] expect_out;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk_vec(input logic [5:0] stim, input logic [9:0] expect_out);
        vec_t v;
        v.stim       = stim;
        v.expect_out = expect_out;
        return v;
    endfunction

    task automatic apply_stimulus(input logic [5:0] stim);
        {reset_n, waitrequest, halt_req, is_load, is_store, is_muldiv} = stim;
    endtask

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [9:0] a_outputs();
        return {a_state, a_mem_read, a_mem_write, a_ir_load, a_pc_en, a_extra, a_busy, a_active, a_fault};
    endfunction

    task automatic do_reset();
        apply_stimulus(6'b0_0_0_000);
        @(negedge clk);
        apply_stimulus(6'b1_0_0_000);
    endtask

    // Runs one mult/div on both instances and checks EXEC2 length, busy cycles and pc_en count.
    task automatic run_muldiv(input string tag);
        int a_exec2 = 0, a_busy_n = 0, a_pce = 0;
        int b_exec2 = 0, b_busy_n = 0, b_pce = 0;
        int overlap = 0;
        logic a_done = 1'b0, b_done = 1'b0;
        apply_stimulus(6'b1_0_0_001);
        for (int cyc = 0; cyc < 20; cyc++) begin
            #2;
            if ((a_pc_en && a_ir_load) || (b_pc_en && b_ir_load)) overlap++;
            if (!a_done) begin
                if (a_state == 2'b10) a_exec2++;
                if (a_busy) a_busy_n++;
                if (a_pc_en) begin
                    a_pce++;
                    a_done = 1'b1;
                end
            end
            if (!b_done) begin
                if (b_state == 2'b10) b_exec2++;
                if (b_busy) b_busy_n++;
                if (b_pc_en) begin
                    b_pce++;
                    b_done = 1'b1;
                end
            end
            @(negedge clk);
            if (a_done && b_done) break;
        end
        check_output({tag, "_a_done"}, 16'(a_done), 16'd1);
        check_output({tag, "_b_done"}, 16'(b_done), 16'd1);
        check_output({tag, "_a_exec2_cycles"}, 16'(a_exec2), 16'd4);
        check_output({tag, "_a_busy_cycles"}, 16'(a_busy_n), 16'd3);
        check_output({tag, "_a_pc_en_count"}, 16'(a_pce), 16'd1);
        check_output({tag, "_b_exec2_cycles"}, 16'(b_exec2), 16'd1);
        check_output({tag, "_b_busy_cycles"}, 16'(b_busy_n), 16'd0);
        check_output({tag, "_b_pc_en_count"}, 16'(b_pce), 16'd1);
        check_output({tag, "_irl_pce_overlap"}, 16'(overlap), 16'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0]  = mk_vec(6'b0_0_0_000, 10'b00_0000_0010);
        vecs[1]  = mk_vec(6'b1_0_0_000, 10'b00_1010_0010);
        vecs[2]  = mk_vec(6'b1_0_0_000, 10'b01_0001_0010);
        vecs[3]  = mk_vec(6'b1_1_0_100, 10'b00_1000_0010);
        vecs[4]  = mk_vec(6'b1_1_0_100, 10'b00_1000_0010);
        vecs[5]  = mk_vec(6'b1_1_0_100, 10'b00_1000_0010);
        vecs[6]  = mk_vec(6'b1_0_0_100, 10'b00_1010_0010);
        vecs[7]  = mk_vec(6'b1_1_0_100, 10'b01_1000_1010);
        vecs[8]  = mk_vec(6'b1_1_0_100, 10'b01_1000_1010);
        vecs[9]  = mk_vec(6'b1_0_0_100, 10'b01_1000_1010);
        vecs[10] = mk_vec(6'b1_0_0_100, 10'b10_0001_1010);
        vecs[11] = mk_vec(6'b1_0_0_010, 10'b00_1010_0010);
        vecs[12] = mk_vec(6'b1_1_0_010, 10'b01_0100_0010);
        vecs[13] = mk_vec(6'b1_0_0_010, 10'b01_0101_0010);
        vecs[14] = mk_vec(6'b1_0_0_001, 10'b00_1010_0010);
        vecs[15] = mk_vec(6'b1_1_0_001, 10'b01_0000_1010);
        vecs[16] = mk_vec(6'b1_0_0_001, 10'b10_0000_1110);
        vecs[17] = mk_vec(6'b1_0_0_001, 10'b10_0000_1110);
        vecs[18] = mk_vec(6'b1_0_0_001, 10'b10_0000_1110);
        vecs[19] = mk_vec(6'b1_0_0_001, 10'b10_0001_1010);
        vecs[20] = mk_vec(6'b1_0_0_110, 10'b00_1010_0010);
        vecs[21] = mk_vec(6'b1_0_0_110, 10'b01_1000_1010);
        vecs[22] = mk_vec(6'b1_0_0_110, 10'b10_0001_1010);
        vecs[23] = mk_vec(6'b1_0_0_011, 10'b00_1010_0010);
        vecs[24] = mk_vec(6'b1_0_0_011, 10'b01_0101_1010);
        vecs[25] = mk_vec(6'b1_1_1_000, 10'b00_0000_0010);
        vecs[26] = mk_vec(6'b1_0_0_100, 10'b11_0000_0000);
        vecs[27] = mk_vec(6'b1_0_0_000, 10'b11_0000_0000);
        vecs[28] = mk_vec(6'b0_0_0_000, 10'b00_0000_0010);

        apply_stimulus(6'b0_0_0_000);
        @(negedge clk);

        // One vector per clock: drive after the falling edge, sample shortly after.
        for (int i = 0; i < 29; i++) begin
            apply_stimulus(vecs[i].stim);
            #2;
            check_output($sformatf("vec%0d", i), 16'(a_outputs()), 16'(vecs[i].expect_out));
            @(negedge clk);
        end

        // MULT with 4 and 1 configured EXEC2 cycles.
        do_reset();
        run_muldiv("mult");

        // Reset pulsed mid-EXEC2 of a DIV.
        do_reset();
        apply_stimulus(6'b1_0_0_001);
        repeat (3) @(negedge clk);
        #2;
        check_output("div_mid_exec2_state", 16'(a_state), 16'd2);
        check_output("div_mid_exec2_busy", 16'(a_busy), 16'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("div_reset_state", 16'(a_state), 16'd0);
        check_output("div_reset_busy", 16'(a_busy), 16'd0);
        check_output("div_reset_pc_en", 16'(a_pc_en), 16'd0);
        check_output("div_reset_mem_read", 16'(a_mem_read), 16'd0);
        @(negedge clk);
        apply_stimulus(6'b1_1_0_001);
        #2;
        check_output("div_post_reset_state", 16'(a_state), 16'd0);
        check_output("div_post_reset_pc_en", 16'(a_pc_en), 16'd0);
        check_output("div_post_reset_mem_read", 16'(a_mem_read), 16'd1);
        @(negedge clk);
        run_muldiv("div_after_reset");

        // waitrequest stuck high in FETCH.
        do_reset();
        apply_stimulus(6'b1_1_0_000);
        for (int k = 0; k < 8; k++) begin
            #2;
            check_output($sformatf("stall%0d_state", k), 16'(a_state), 16'd0);
            check_output($sformatf("stall%0d_fault", k), 16'(a_fault), 16'd0);
            @(negedge clk);
        end
        #2;
`ifdef MIPS_CTRL_WATCHDOG_EN
        check_output("wd_state", 16'(a_state), 16'd3);
        check_output("wd_fault", 16'(a_fault), 16'd1);
        check_output("wd_mem_read", 16'(a_mem_read), 16'd0);
        check_output("wd_active", 16'(a_active), 16'd0);
`else
        check_output("nowd_state", 16'(a_state), 16'd0);
        check_output("nowd_fault", 16'(a_fault), 16'd0);
        check_output("nowd_mem_read", 16'(a_mem_read), 16'd1);
        check_output("nowd_active", 16'(a_active), 16'd1);
`endif
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
